// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares the single UART transmitter between three byte-stream requesters:
// string printer, RX echo path and command responder. Grants go round-robin.
// Once a requester is granted, the transmitter stays locked to it until it
// presents a byte flagged as last, or until it leaves req low for too long.
// Each byte goes out as a one-cycle tx_enable pulse, and the arbiter paces
// itself on the transmitter's tx_state.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req[i]     requester i presents a valid byte
//   data_in    byte of requester i on data_in[8*i+:8]
//   last[i]    presented byte is the final byte of requester i's message
//   ack[i]     one-cycle pulse: requester i's byte was taken
//   tx_state   transmitter state, 0 = idle
//   tx_data    byte to transmit
//   tx_enable  one-cycle start pulse to the transmitter
//   owner      current grant/lock holder 0..2, 3 = none
//   busy       high in every state except IDLE
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no owner; grant round-robin once the transmitter is idle
// ISSUE      | tx_enable/ack pulse cycle
// WAIT_START | wait for the transmitter to leave idle
// WAIT_DONE  | wait for the transmitter to return to idle
// HOLD       | locked to owner; wait for its next byte or time out
module uart_tx_arbiter #(
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] data_in,
    input  logic [2:0]  last,
    output logic [2:0]  ack,
    input  logic [1:0]  tx_state,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT = 8'(HOLD_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, HOLD} state_t;

    state_t     state, state_n;
    logic [1:0] rr_last, rr_last_n;
    logic [1:0] owner_n;
    logic       lock_end, lock_end_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [7:0] tx_data_n;
    logic       tx_enable_n;
    logic [2:0] ack_n;
    logic       busy_n;

    logic [1:0] grant;
    logic [1:0] sel;
    logic [7:0] sel_byte;
    logic       sel_last;
    logic       req_owner;

    // Round-robin search starting at (rr_last + 1) mod 3. It is only used
    // when req is nonzero.
    always_comb begin
        grant = 2'd0;
        case (rr_last)
            2'd0:    grant = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    grant = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: grant = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // In HOLD the byte comes from the lock owner, and in IDLE it comes from the
    // fresh grant.
    always_comb begin
        sel      = (state == HOLD) ? owner : grant;
        sel_byte = data_in[7:0];
        sel_last = last[0];
        case (sel)
            2'd1:    begin sel_byte = data_in[15:8];  sel_last = last[1]; end
            2'd2:    begin sel_byte = data_in[23:16]; sel_last = last[2]; end
            default: begin sel_byte = data_in[7:0];   sel_last = last[0]; end
        endcase
    end

    always_comb begin
        case (owner)
            2'd0:    req_owner = req[0];
            2'd1:    req_owner = req[1];
            2'd2:    req_owner = req[2];
            default: req_owner = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_last_n   = rr_last;
        lock_end_n  = lock_end;
        hold_cnt_n  = hold_cnt;
        tx_data_n   = tx_data;
        tx_enable_n = 1'b0;
        ack_n       = 3'b000;
        case (state)
            IDLE: begin
                if (tx_state == 2'd0 && req != 3'b000) begin
                    tx_data_n   = sel_byte;
                    owner_n     = grant;
                    rr_last_n   = grant;
                    lock_end_n  = sel_last;
                    tx_enable_n = 1'b1;
                    ack_n       = 3'b001 << grant;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT_START;
            end
            WAIT_START: begin
                // A transmitter that has not left idle yet must not be read
                // as a finished byte.
                if (tx_state != 2'd0) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_state == 2'd0) begin
                    if (lock_end) begin
                        owner_n = 2'd3;
                        state_n = IDLE;
                    end else begin
                        hold_cnt_n = 8'd0;
                        state_n    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_owner) begin
                    tx_data_n   = sel_byte;
                    lock_end_n  = sel_last;
                    tx_enable_n = 1'b1;
                    ack_n       = 3'b001 << owner;
                    state_n     = ISSUE;
                end else if (hold_cnt == TIMEOUT) begin
                    owner_n = 2'd3;
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end
            default: begin
                owner_n = 2'd3;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd3;
            rr_last   <= 2'd2;
            lock_end  <= 1'b0;
            hold_cnt  <= 8'd0;
            tx_data   <= 8'd0;
            tx_enable <= 1'b0;
            ack       <= 3'b000;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_last   <= rr_last_n;
            lock_end  <= lock_end_n;
            hold_cnt  <= hold_cnt_n;
            tx_data   <= tx_data_n;
            tx_enable <= tx_enable_n;
            ack       <= ack_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with HOLD_TIMEOUT = 4.
// Requester drivers and a transmitter model run on the falling edge.
// The scoreboard monitor samples 2 time units after each rising edge.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req;
    logic [23:0] data_in;
    logic [2:0]  last;
    logic [2:0]  ack;
    logic [1:0]  tx_state;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic [1:0]  owner;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.HOLD_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .last      (last),
        .ack       (ack),
        .tx_state  (tx_state),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .owner     (owner),
        .busy      (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Each expected transmission is {requester index, byte}.
    logic [9:0] exp_q[$];
    // Each requester message entry is {last, byte}.
    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [8:0] rq2[$];

    int   stale_delay = 0;
    int   busy_len    = 10;
    logic model_kill  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_byte(input logic [1:0] idx, input logic [7:0] b);
        exp_q.push_back({idx, b});
    endfunction

    // Requesters present the head of their queue and advance on ack.
    task automatic drive_reqs();
        logic [8:0] h;
        forever begin
            @(negedge clk);
            if (ack[0] && rq0.size() > 0) rq0.delete(0);
            if (ack[1] && rq1.size() > 0) rq1.delete(0);
            if (ack[2] && rq2.size() > 0) rq2.delete(0);
            h = (rq0.size() > 0) ? rq0[0] : 9'h000;
            req[0] = (rq0.size() > 0); last[0] = h[8]; data_in[7:0] = h[7:0];
            h = (rq1.size() > 0) ? rq1[0] : 9'h000;
            req[1] = (rq1.size() > 0); last[1] = h[8]; data_in[15:8] = h[7:0];
            h = (rq2.size() > 0) ? rq2[0] : 9'h000;
            req[2] = (rq2.size() > 0); last[2] = h[8]; data_in[23:16] = h[7:0];
        end
    endtask

    // Transmitter: on tx_enable it idles for stale_delay cycles and is then
    // busy for busy_len cycles. It ignores rst.
    task automatic tx_model();
        int pend;
        int left;
        bit active;
        pend = 0; left = 0; active = 1'b0;
        forever begin
            @(negedge clk);
            if (model_kill) begin
                active   = 1'b0;
                tx_state = 2'd0;
            end else begin
                if (tx_enable) begin
                    pend   = stale_delay;
                    left   = busy_len;
                    active = 1'b1;
                end
                if (active) begin
                    if (pend > 0) begin
                        pend--;
                        tx_state = 2'd0;
                    end else if (left > 0) begin
                        left--;
                        tx_state = 2'd1;
                    end else begin
                        tx_state = 2'd0;
                        active   = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        logic [9:0] e;
        bit await_busy;
        await_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tx_enable) begin
                check("enable_while_tx_busy", int'(tx_state), 0);
                check("enable_before_tx_cycle", int'(await_busy), 0);
                await_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_enable: tx_data %0h ack %0h, expected no byte", tx_data, ack);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", int'(tx_data), int'(e[7:0]));
                    check("ack", int'(ack), int'(3'b001 << e[9:8]));
                    check("owner_at_issue", int'(owner), int'(e[9:8]));
                end
            end else if (ack != 3'b000) begin
                check("ack_without_enable", int'(ack), 0);
            end
            if (tx_state != 2'd0) await_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        model_kill = 1'b1;
        rq0.delete(); rq1.delete(); rq2.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3;
        rst        = 1'b0;
        model_kill = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || tx_state != 2'd0) && n < 2000) begin
            @(posedge clk);
            #3;
            n++;
        end
        check({name, "_completed"}, int'(n < 2000), 1);
        check({name, "_owner_end"}, int'(owner), 3);
        check({name, "_busy_end"}, int'(busy), 0);
        check({name, "_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_tx(input bit want_busy, input string name);
        int n;
        n = 0;
        while (((tx_state != 2'd0) != want_busy) && n < 200) begin
            @(posedge clk);
            #3;
            n++;
        end
        check(name, int'(n < 200), 1);
    endtask

    int k;

    initial begin
        req = 3'b000; data_in = 24'h0; last = 3'b000; tx_state = 2'd0;
        fork
            drive_reqs();
            tx_model();
            monitor();
        join_none

        #1;
        rst = 1'b1;
        #1;
        check("reset_owner", int'(owner), 3);
        check("reset_busy", int'(busy), 0);
        check("reset_enable", int'(tx_enable), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_tx_data", int'(tx_data), 0);

        // Single byte.
        do_reset();
        busy_len = 10; stale_delay = 0;
        expect_byte(2'd0, 8'h41);
        rq0.push_back({1'b1, 8'h41});
        wait_done("single");

        // Contention: after reset the grant order is 0, 1, 2, 0.
        do_reset();
        busy_len = 4;
        expect_byte(2'd0, 8'h10);
        expect_byte(2'd1, 8'h11);
        expect_byte(2'd2, 8'h12);
        expect_byte(2'd0, 8'h13);
        rq0.push_back({1'b1, 8'h10}); rq0.push_back({1'b1, 8'h13});
        rq1.push_back({1'b1, 8'h11});
        rq2.push_back({1'b1, 8'h12});
        wait_done("contention");

        // Lock: requester 1 sends "OK\n" while requester 2 is waiting.
        do_reset();
        busy_len = 5;
        expect_byte(2'd1, 8'h4F);
        expect_byte(2'd1, 8'h4B);
        expect_byte(2'd1, 8'h0A);
        expect_byte(2'd2, 8'h77);
        rq1.push_back({1'b0, 8'h4F}); rq1.push_back({1'b0, 8'h4B});
        rq1.push_back({1'b1, 8'h0A});
        rq2.push_back({1'b1, 8'h77});
        wait_done("lock");

        // Hold timeout: owner 0 holds for 5 HOLD cycles and ignores requester 1.
        do_reset();
        busy_len = 6;
        expect_byte(2'd0, 8'h55);
        rq0.push_back({1'b0, 8'h55});
        wait_tx(1'b1, "hold_tx_started");
        wait_tx(1'b0, "hold_tx_finished");
        check("hold_first_owner", int'(owner), 0);
        expect_byte(2'd1, 8'h66);
        rq1.push_back({1'b1, 8'h66});
        k = 0;
        while (owner == 2'd0 && k < 20) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("hold_cycles", k, 5);
        check("hold_owner_after_timeout", int'(owner), 3);
        wait_done("hold");

        // Stale idle: transmitter stays idle 3 cycles after each enable.
        do_reset();
        busy_len = 6; stale_delay = 3;
        expect_byte(2'd0, 8'h21);
        expect_byte(2'd0, 8'h22);
        rq0.push_back({1'b0, 8'h21}); rq0.push_back({1'b1, 8'h22});
        wait_done("stale");
        stale_delay = 0;

        // Reset during WAIT_DONE of a locked message.
        do_reset();
        busy_len = 10;
        expect_byte(2'd0, 8'h31);
        rq0.push_back({1'b0, 8'h31}); rq0.push_back({1'b0, 8'h32});
        rq0.push_back({1'b1, 8'h33});
        wait_tx(1'b1, "rstmid_tx_started");
        @(posedge clk);
        #3;
        check("rstmid_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rstmid_enable", int'(tx_enable), 0);
        check("rstmid_ack", int'(ack), 0);
        check("rstmid_owner", int'(owner), 3);
        check("rstmid_busy", int'(busy), 0);
        expect_byte(2'd0, 8'h32);
        expect_byte(2'd0, 8'h33);
        expect_byte(2'd1, 8'h44);
        rq1.push_back({1'b1, 8'h44});
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        wait_done("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
